// File: rtl/rom_reader_pkg.sv
// Shared constants for the rom_reader slice: FSM state codes and pipeline/buffer sizes.
package rom_reader_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int SKID_DEPTH  = 2;
  localparam int ROM_LATENCY = 1;

endpackage

// File: rtl/rom_reader_skid.sv
// Registered output stage backed by a SKID_DEPTH-entry FIFO; a push goes straight
// to the output register when it is free and the FIFO is empty.
module rom_reader_skid
  import rom_reader_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  output logic [1:0]       count_nxt_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [WIDTH-1:0] mem_d [SKID_DEPTH];
  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_vld_q, out_vld_d;
  logic             pop_s, out_free_s, take_s, bypass_s, put_s;

  // Next-state for output register and backing FIFO (head at mem[0]).
  always_comb begin
    pop_s      = out_vld_q && ready_i;
    out_free_s = !out_vld_q || pop_s;
    take_s     = out_free_s && (cnt_q != 2'd0);
    bypass_s   = out_free_s && (cnt_q == 2'd0) && push_i;
    put_s      = push_i && !bypass_s;
    mem_d      = mem_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    if (take_s) begin
      out_d     = mem_q[0];
      out_vld_d = 1'b1;
      mem_d[0]  = mem_q[1];
      cnt_d     = cnt_q - 2'd1;
    end else if (bypass_s) begin
      out_d     = push_data_i;
      out_vld_d = 1'b1;
    end else if (pop_s) begin
      out_vld_d = 1'b0;
    end else begin
      out_vld_d = out_vld_q;
    end
    if (put_s && (cnt_d < 2'(SKID_DEPTH))) begin
      mem_d[cnt_d[0]] = push_data_i;
      cnt_d           = cnt_d + 2'd1;
    end else begin
      cnt_d = cnt_d;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q     <= '{default: '0};
      cnt_q     <= 2'd0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign m_data_o    = out_q;
  assign m_valid_o   = out_vld_q;
  assign count_nxt_o = cnt_d;
  assign empty_o     = (cnt_q == 2'd0);
  assign full_o      = (cnt_q == 2'(SKID_DEPTH));

endmodule

// File: rtl/rom_reader.sv
// Sweeps `length` ROM words from `base_addr` (mod DEPTH) onto a valid/ready stream.
// Define ROM_READER_LOOP_EN to add a `stop` input and repeat the sweep until stopped.
module rom_reader
  import rom_reader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [AW:0]      length,
`ifdef ROM_READER_LOOP_EN
  input  logic             stop,
`endif
  output logic             busy,
  output logic             done,
  output logic             rom_en,
  output logic [AW-1:0]    rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [1:0]         state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d, rom_addr_q, rom_addr_d;
  logic [AW:0]        rem_q, rem_d;
  logic [ROM_LATENCY:0] pipe_q;   // bit 0 drives rom_en, top bit marks data arriving now
  logic               rom_en_d, done_q, done_d, busy_q;
  logic [AW:0]        len_eff_s, cur_rem_s, lap_len_s;
  logic [AW-1:0]      cur_addr_s, lap_base_s;
  logic               lap_again_s, credit_ok_s, issue_s, drain_done_s;
  logic [1:0]         skid_cnt_nxt_s;
  logic               skid_empty_s, skid_full_s, skid_valid_s;

  assign len_eff_s  = (length > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : length;
  assign cur_addr_s = (state_q == S_IDLE) ? base_addr : addr_q;
  assign cur_rem_s  = (state_q == S_IDLE) ? len_eff_s : rem_q;

`ifdef ROM_READER_LOOP_EN
  logic [AW-1:0] base_q;
  logic [AW:0]   len_q;
  logic          stop_seen_q;

  assign lap_base_s  = (state_q == S_IDLE) ? base_addr : base_q;
  assign lap_len_s   = (state_q == S_IDLE) ? len_eff_s : len_q;
  assign lap_again_s = !(stop_seen_q || (stop && (state_q == S_RUN)));

  // Lap parameters and the sticky stop request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q      <= '0;
      len_q       <= '0;
      stop_seen_q <= 1'b0;
    end else if (state_q == S_IDLE) begin
      base_q      <= base_addr;
      len_q       <= len_eff_s;
      stop_seen_q <= 1'b0;
    end else begin
      stop_seen_q <= stop_seen_q || (stop && (state_q == S_RUN));
    end
  end
`else
  assign lap_base_s  = base_addr;
  assign lap_len_s   = len_eff_s;
  assign lap_again_s = 1'b0;
`endif

  // Issue only if everything in the FIFO or still travelling fits in the backing entries.
  assign credit_ok_s  = (int'(skid_cnt_nxt_s) + $countones(pipe_q[ROM_LATENCY-1:0]) + 1)
                        <= SKID_DEPTH;
  assign issue_s      = ((state_q == S_IDLE) && start && (len_eff_s != '0)) ||
                        ((state_q == S_RUN) && (rem_q != '0) && credit_ok_s && !skid_full_s);
  assign drain_done_s = (pipe_q == '0) && skid_empty_s && (!skid_valid_s || m_ready);

  // FSM, address counter and remaining-word counter.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    rom_addr_d = rom_addr_q;
    rom_en_d   = 1'b0;
    done_d     = 1'b0;
    if (issue_s) begin
      rom_en_d   = 1'b1;
      rom_addr_d = cur_addr_s;
      if (cur_rem_s == (AW+1)'(1)) begin
        if (lap_again_s) begin
          addr_d  = lap_base_s;
          rem_d   = lap_len_s;
          state_d = S_RUN;
        end else begin
          addr_d  = cur_addr_s + AW'(1);
          rem_d   = '0;
          state_d = S_DRAIN;
        end
      end else begin
        addr_d  = cur_addr_s + AW'(1);
        rem_d   = cur_rem_s - (AW+1)'(1);
        state_d = S_RUN;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) done_d = 1'b1;   // zero-length request
          else       done_d = 1'b0;
        end
        S_RUN:   state_d = S_RUN;
        S_DRAIN: begin
          if (drain_done_s) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control and ROM-side registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      pipe_q     <= '0;
      rom_addr_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      pipe_q     <= {pipe_q[ROM_LATENCY-1:0], rom_en_d};
      rom_addr_q <= rom_addr_d;
      done_q     <= done_d;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  rom_reader_skid #(.WIDTH(WIDTH)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (pipe_q[ROM_LATENCY]),
    .push_data_i (rom_data),
    .ready_i     (m_ready),
    .m_data_o    (m_data),
    .m_valid_o   (skid_valid_s),
    .count_nxt_o (skid_cnt_nxt_s),
    .empty_o     (skid_empty_s),
    .full_o      (skid_full_s)
  );

  assign m_valid  = skid_valid_s;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rom_en   = pipe_q[0];
  assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_rom_reader.sv
// Self-checking bench for rom_reader against a queue-based model of the word stream.
module tb_rom_reader;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst, start, m_ready;
  logic [AW-1:0]    base_addr;
  logic [AW:0]      length;
  logic             busy, done, rom_en, m_valid;
  logic [AW-1:0]    rom_addr;
  logic [WIDTH-1:0] rom_data, m_data;
`ifdef ROM_READER_LOOP_EN
  logic             stop;
`endif

  rom_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
`ifdef ROM_READER_LOOP_EN
    .stop(stop),
`endif
    .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with content data = addr ^ 8'hA5.
  always @(posedge clk) begin
    if (rom_en) rom_data <= {{(WIDTH-AW){1'b0}}, rom_addr} ^ 8'hA5;
  end

  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [AW-1:0]    addr_log[$];
  int               acc_cnt = 0;
  int               done_cnt = 0;
  logic             hold_v = 1'b0;
  logic [WIDTH-1:0] hold_d = '0;

  function automatic int clamp(int l);
    return (l > DEPTH) ? DEPTH : l;
  endfunction

  function automatic logic [WIDTH-1:0] word_at(int a);
    logic [WIDTH-1:0] w;
    w = WIDTH'(a % DEPTH) ^ 8'hA5;
    return w;
  endfunction

  // One clock: observe at the falling edge (scoreboard), return just after the rising edge.
  task automatic step();
    logic [WIDTH-1:0] e;
    @(negedge clk);
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        checks++;
        if (!m_valid || m_data !== hold_d) begin
          failures++;
          $display("FAIL hold_stable: m_valid=%0b m_data=%h required valid=1 data=%h", m_valid, m_data, hold_d);
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_word: got %h, no word expected", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            failures++;
            $display("FAIL word_order: got %h required %h", m_data, e);
          end
        end
        acc_cnt++;
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      if (rom_en) addr_log.push_back(rom_addr);
      if (done) done_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(int b, int l);
    start = 1'b1;
    base_addr = AW'(b);
    length = (AW+1)'(l);
    for (int i = 0; i < clamp(l); i++) exp_q.push_back(word_at(b + i));
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(int budget, bit rand_rdy);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) begin
      if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
      step();
    end
    m_ready = 1'b1;
    checks++;
    if (done_cnt != d0 + 1) begin
      failures++;
      $display("FAIL done_seen: done pulses=%0d required 1", done_cnt - d0);
    end
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse_width: done=%0b busy=%0b required 0 0", done, busy);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL words_missing: %0d words never delivered", exp_q.size());
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy, done, rom_en, m_valid} !== 4'b0 || rom_addr !== '0 || m_data !== '0) begin
      failures++;
      $display("FAIL reset_state: busy=%0b done=%0b rom_en=%0b rom_addr=%0d m_valid=%0b m_data=%h required all 0",
               busy, done, rom_en, rom_addr, m_valid, m_data);
    end
  endtask

  task automatic test_basic();
    int a0 = acc_cnt;
    m_ready = 1'b1;
    do_start(0, 8);
    checks++;
    if (rom_en !== 1'b1 || rom_addr !== 3'd0 || busy !== 1'b1 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL first_issue: rom_en=%0b rom_addr=%0d busy=%0b m_valid=%0b required 1 0 1 0",
               rom_en, rom_addr, busy, m_valid);
    end
    step();
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early: m_valid=%0b required 0 two cycles after start", m_valid);
    end
    step();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      failures++;
      $display("FAIL latency_first: m_valid=%0b m_data=%h required 1 a5", m_valid, m_data);
    end
    for (int i = 1; i < 8; i++) begin
      step();
      checks++;
      if (m_valid !== 1'b1) begin
        failures++;
        $display("FAIL throughput: m_valid=%0b at word %0d required 1", m_valid, i);
      end
    end
    wait_done(20, 1'b0);
    checks++;
    if (acc_cnt - a0 != 8) begin
      failures++;
      $display("FAIL basic_count: %0d words required 8", acc_cnt - a0);
    end
  endtask

  task automatic test_wrap();
    int exp_a[4] = '{6, 7, 0, 1};
    addr_log.delete();
    do_start(6, 4);
    wait_done(30, 1'b0);
    checks++;
    if (addr_log.size() != 4) begin
      failures++;
      $display("FAIL wrap_issue_count: %0d reads required 4", addr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (addr_log[i] !== AW'(exp_a[i])) begin
          failures++;
          $display("FAIL wrap_addr: read %0d addr %0d required %0d", i, addr_log[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int a0 = acc_cnt;
    m_ready = 1'b1;
    do_start(1, 8);
    for (int i = 0; i < 20 && acc_cnt - a0 < 2; i++) step();
    m_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k >= 2) begin
        checks++;
        if (rom_en !== 1'b0) begin
          failures++;
          $display("FAIL bp_rom_en: rom_en=%0b %0d cycles into stall required 0", rom_en, k);
        end
      end
    end
    m_ready = 1'b1;
    wait_done(40, 1'b0);
    checks++;
    if (acc_cnt - a0 != 8) begin
      failures++;
      $display("FAIL bp_count: %0d words required 8", acc_cnt - a0);
    end
  endtask

  task automatic test_zero_len();
    int d0 = done_cnt;
    addr_log.delete();
    start = 1'b1;
    base_addr = 3'd5;
    length = '0;
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || rom_en !== 1'b0) begin
      failures++;
      $display("FAIL zero_len_done: done=%0b busy=%0b rom_en=%0b required 1 0 0", done, busy, rom_en);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (rom_en !== 1'b0 || m_valid !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL zero_len_quiet: rom_en=%0b m_valid=%0b done=%0b required 0 0 0", rom_en, m_valid, done);
      end
    end
    checks++;
    if (done_cnt != d0 + 1 || addr_log.size() != 0) begin
      failures++;
      $display("FAIL zero_len_totals: done pulses=%0d reads=%0d required 1 0", done_cnt - d0, addr_log.size());
    end
  endtask

  task automatic test_start_busy();
    int a0 = acc_cnt;
    do_start(3, 5);
    step();
    start = 1'b1;
    base_addr = 3'd0;
    length = 4'd8;
    step();
    start = 1'b0;
    wait_done(40, 1'b0);
    checks++;
    if (acc_cnt - a0 != 5) begin
      failures++;
      $display("FAIL start_busy_count: %0d words required 5", acc_cnt - a0);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (m_valid !== 1'b0 || rom_en !== 1'b0) begin
        failures++;
        $display("FAIL start_busy_extra: m_valid=%0b rom_en=%0b required 0 0", m_valid, rom_en);
      end
    end
  endtask

  task automatic test_reset_mid();
    int a0 = acc_cnt;
    int d0;
    m_ready = 1'b1;
    do_start(0, 8);
    for (int i = 0; i < 20 && acc_cnt - a0 < 3; i++) step();
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, rom_en, m_valid} !== 4'b0 || rom_addr !== '0 || m_data !== '0) begin
      failures++;
      $display("FAIL reset_mid: busy=%0b done=%0b rom_en=%0b rom_addr=%0d m_valid=%0b m_data=%h required all 0",
               busy, done, rom_en, rom_addr, m_valid, m_data);
    end
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (m_valid !== 1'b0 || done_cnt != d0) begin
        failures++;
        $display("FAIL reset_mid_quiet: m_valid=%0b done pulses=%0d required 0 0", m_valid, done_cnt - d0);
      end
    end
    a0 = acc_cnt;
    do_start(5, 8);
    wait_done(40, 1'b0);
    checks++;
    if (acc_cnt - a0 != 8) begin
      failures++;
      $display("FAIL reset_mid_restart: %0d words required 8", acc_cnt - a0);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 15; t++) begin
      int a0 = acc_cnt;
      int b = int'($urandom_range(0, DEPTH - 1));
      int l = int'($urandom_range(0, 2 * DEPTH - 1));
      m_ready = 1'($urandom_range(0, 1));
      do_start(b, l);
      wait_done(300, 1'b1);
      checks++;
      if (acc_cnt - a0 != clamp(l)) begin
        failures++;
        $display("FAIL random_count: base=%0d len=%0d got %0d words required %0d", b, l, acc_cnt - a0, clamp(l));
      end
    end
  endtask

`ifdef ROM_READER_LOOP_EN
  task automatic test_loop();
    int exp_a[6] = '{2, 3, 4, 2, 3, 4};
    m_ready = 1'b1;
    addr_log.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(word_at(2 + i));
    do_start(2, 3);
    for (int i = 0; i < 20 && addr_log.size() < 4; i++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_done(40, 1'b0);
    checks++;
    if (addr_log.size() != 6) begin
      failures++;
      $display("FAIL loop_issue_count: %0d reads required 6", addr_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (addr_log[i] !== AW'(exp_a[i])) begin
          failures++;
          $display("FAIL loop_addr: read %0d addr %0d required %0d", i, addr_log[i], exp_a[i]);
        end
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    m_ready = 1'b0;
    rom_data = '0;
`ifdef ROM_READER_LOOP_EN
    stop = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    step();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_start_busy();
    test_reset_mid();
    test_random();
`ifdef ROM_READER_LOOP_EN
    test_loop();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
